// File: rtl/regfile_listseq_if.sv
// Register-list sequencer bus between the register file and the control/load-store side.
// The master side issues list requests and accepts beats; the slave side is the register file.
interface regfile_listseq_if #(
  parameter int WIDE = 32
);
  logic            list_start;
  logic [15:0]     list_mask;
  logic            list_pop;
  logic            list_valid;
  logic            list_ready;
  logic [3:0]      list_sel;
  logic [WIDE-1:0] list_addr;
  logic [WIDE-1:0] list_rdata;
  logic [WIDE-1:0] list_wdata;
  logic            list_busy;
  logic            list_done;

  modport master (
    output list_start, list_mask, list_pop, list_ready, list_wdata,
    input  list_valid, list_sel, list_addr, list_rdata, list_busy, list_done
  );

  modport slave (
    input  list_start, list_mask, list_pop, list_ready, list_wdata,
    output list_valid, list_sel, list_addr, list_rdata, list_busy, list_done
  );
endinterface

// File: rtl/regfile_listseq.sv
// CPU register file (R0..R12, SP, LR, PC, TMP1, CPSR) with a PUSH/POP register-list sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
//
// state | meaning
// IDLE  | waiting for list_start
// BUSY  | presenting one beat per cycle until the last beat is accepted
// DONE  | one-cycle completion, SP adjusted by the transfer size
module regfile_listseq #(
  parameter int              WIDE      = 32,
  parameter int              NGPR      = 13,
  parameter logic [WIDE-1:0] SP_RESET  = 32'h0000_1FFC,
  parameter logic [WIDE-1:0] PC_RESET  = 32'h0000_0002,
  parameter int              PC_WR_OFS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      readA_sel,
  input  logic [4:0]      readB_sel,
  input  logic [4:0]      readC_sel,
  input  logic [4:0]      readD_sel,
  output logic [WIDE-1:0] regA_out,
  output logic [WIDE-1:0] regB_out,
  output logic [WIDE-1:0] regC_out,
  output logic [WIDE-1:0] regD_out,
  input  logic [WIDE-1:0] immediate1_in,
  input  logic [WIDE-1:0] immediate2_in,
  input  logic [4:0]      write1_sel,
  input  logic [4:0]      write2_sel,
  input  logic            write1_en,
  input  logic            write2_en,
  input  logic [WIDE-1:0] write1_in,
  input  logic [WIDE-1:0] write2_in,
  input  logic [WIDE-1:0] next_pc_in,
  input  logic            next_pc_en,
  input  logic [WIDE-1:0] next_sp_in,
  input  logic            next_sp_en,
  input  logic [3:0]      next_cpsr_in,
  output logic [WIDE-1:0] pc_out,
  output logic [WIDE-1:0] sp_out,
  output logic [3:0]      cpsr_out,
  regfile_listseq_if.slave list_if
);

  localparam logic [WIDE-1:0] PC_OFS = WIDE'(PC_WR_OFS);

  function automatic logic [15:0] impl_mask_f();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (i < NGPR) || (i >= 14);
    return m;
  endfunction

  // SP is never part of a list transfer; it is adjusted once at the end instead.
  localparam logic [15:0] IMPL_MASK = impl_mask_f();

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_nxt;
  logic [WIDE-1:0] regs     [16];
  logic [WIDE-1:0] regs_nxt [16];
  logic [WIDE-1:0] rd_view  [32];
  logic [WIDE-1:0] tmp1_q, tmp1_nxt;
  logic [3:0]      cpsr_q;

  logic [15:0]     rem_q;
  logic [4:0]      beat_q, n_q;
  logic [WIDE-1:0] base_q;
  logic            pop_q;

  logic [15:0]     eff_mask;
  logic [4:0]      n_start;
  logic [3:0]      sel_cur;
  logic            start_ok, accept, pop_wr, sp_upd;
  logic [WIDE-1:0] n4_start, n4_q, sp_new;

  always_comb begin
    eff_mask = list_if.list_mask & IMPL_MASK;
    n_start  = '0;
    for (int i = 0; i < 16; i++) n_start = n_start + 5'(eff_mask[i]);
    sel_cur = '0;
    for (int i = 15; i >= 0; i--) if (rem_q[i]) sel_cur = 4'(i);
  end

  assign n4_start = WIDE'(n_start) << 2;
  assign n4_q     = WIDE'(n_q) << 2;
  assign start_ok = (state_q == IDLE) && list_if.list_start;
  assign accept   = (state_q == BUSY) && list_if.list_ready;
  assign pop_wr   = accept && pop_q;
  assign sp_upd   = (state_q == DONE);
  assign sp_new   = pop_q ? regs[13] + n4_q : regs[13] - n4_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt          = state_q;
    list_if.list_valid = 1'b0;
    list_if.list_done  = 1'b0;
    list_if.list_busy  = (state_q != IDLE);
    list_if.list_sel   = '0;
    list_if.list_addr  = '0;
    list_if.list_rdata = '0;
    case (state_q)
      IDLE: begin
        if (list_if.list_start) state_nxt = (n_start == 5'd0) ? DONE : BUSY;
      end
      BUSY: begin
        list_if.list_valid = 1'b1;
        list_if.list_sel   = sel_cur;
        list_if.list_addr  = base_q + (WIDE'(beat_q) << 2);
        if (!pop_q) list_if.list_rdata = regs[sel_cur];
        if (list_if.list_ready && ((rem_q & (rem_q - 16'd1)) == 16'd0)) state_nxt = DONE;
      end
      DONE: begin
        list_if.list_done = 1'b1;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      beat_q <= '0;
      n_q    <= '0;
      base_q <= '0;
      pop_q  <= 1'b0;
    end else if (start_ok) begin
      rem_q  <= eff_mask;
      beat_q <= '0;
      n_q    <= n_start;
      base_q <= list_if.list_pop ? regs[13] : regs[13] - n4_start;
      pop_q  <= list_if.list_pop;
    end else if (accept) begin
      rem_q  <= rem_q & (rem_q - 16'd1);
      beat_q <= beat_q + 5'd1;
    end
  end

  // Later assignments win: dedicated input < write2 < write1 < POP beat < SP completion.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_nxt[i] = regs[i];
      if (i == 15 && next_pc_en) regs_nxt[i] = next_pc_in;
      if (i == 13 && next_sp_en) regs_nxt[i] = next_sp_in;
      if (write2_en && write2_sel == 5'(i)) regs_nxt[i] = write2_in + ((i == 15) ? PC_OFS : '0);
      if (write1_en && write1_sel == 5'(i)) regs_nxt[i] = write1_in + ((i == 15) ? PC_OFS : '0);
      if (pop_wr && sel_cur == 4'(i)) regs_nxt[i] = list_if.list_wdata + ((i == 15) ? PC_OFS : '0);
      if (i == 13 && sp_upd) regs_nxt[i] = sp_new;
      if (i >= NGPR && i < 13) regs_nxt[i] = '0;
    end
    tmp1_nxt = tmp1_q;
    if (write2_en && write2_sel == 5'd30) tmp1_nxt = write2_in;
    if (write1_en && write1_sel == 5'd30) tmp1_nxt = write1_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      regs[13] <= SP_RESET;
      regs[15] <= PC_RESET;
      tmp1_q   <= '0;
      cpsr_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) regs[i] <= regs_nxt[i];
      tmp1_q <= tmp1_nxt;
      cpsr_q <= next_cpsr_in;
    end
  end

`ifdef REGFILE_BYPASS_EN
  function automatic logic wr_ok(input logic [4:0] sel);
    return (sel < 5'(NGPR)) || (sel >= 5'd13 && sel <= 5'd15) || (sel == 5'd30);
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < 32; i++) rd_view[i] = '0;
    for (int i = 0; i < 16; i++) rd_view[i] = regs[i];
    rd_view[30] = tmp1_q;
`ifdef REGFILE_BYPASS_EN
    if (write2_en && wr_ok(write2_sel))
      rd_view[write2_sel] = write2_in + ((write2_sel == 5'd15) ? PC_OFS : '0);
    if (write1_en && wr_ok(write1_sel))
      rd_view[write1_sel] = write1_in + ((write1_sel == 5'd15) ? PC_OFS : '0);
`endif
  end

  assign regA_out = (readA_sel == 5'd31) ? immediate1_in : rd_view[readA_sel];
  assign regB_out = (readB_sel == 5'd31) ? immediate2_in : rd_view[readB_sel];
  assign regC_out = (readC_sel >= 5'd30) ? '0 : rd_view[readC_sel];
  assign regD_out = (readD_sel >= 5'd30) ? '0 : rd_view[readD_sel];

  assign pc_out   = regs[15];
  assign sp_out   = regs[13];
  assign cpsr_out = cpsr_q;

endmodule

// File: tb/tb_regfile_listseq.sv
// Self-checking bench for regfile_listseq: directed steps plus randomized traffic
// compared against a register-level reference model.
module tb_regfile_listseq;
  localparam int WIDE = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      readA_sel, readB_sel, readC_sel, readD_sel;
  logic [WIDE-1:0] regA_out, regB_out, regC_out, regD_out;
  logic [WIDE-1:0] immediate1_in, immediate2_in;
  logic [4:0]      write1_sel, write2_sel;
  logic            write1_en, write2_en;
  logic [WIDE-1:0] write1_in, write2_in;
  logic [WIDE-1:0] next_pc_in, next_sp_in;
  logic            next_pc_en, next_sp_en;
  logic [3:0]      next_cpsr_in;
  logic [WIDE-1:0] pc_out, sp_out;
  logic [3:0]      cpsr_out;

  regfile_listseq_if #(.WIDE(WIDE)) lif ();

  regfile_listseq #(.WIDE(WIDE)) dut (
    .clk(clk), .reset(reset),
    .readA_sel(readA_sel), .readB_sel(readB_sel), .readC_sel(readC_sel), .readD_sel(readD_sel),
    .regA_out(regA_out), .regB_out(regB_out), .regC_out(regC_out), .regD_out(regD_out),
    .immediate1_in(immediate1_in), .immediate2_in(immediate2_in),
    .write1_sel(write1_sel), .write2_sel(write2_sel), .write1_en(write1_en), .write2_en(write2_en),
    .write1_in(write1_in), .write2_in(write2_in),
    .next_pc_in(next_pc_in), .next_pc_en(next_pc_en),
    .next_sp_in(next_sp_in), .next_sp_en(next_sp_en),
    .next_cpsr_in(next_cpsr_in),
    .pc_out(pc_out), .sp_out(sp_out), .cpsr_out(cpsr_out),
    .list_if(lif)
  );

  always #5 clk = ~clk;

  logic [31:0] m_r [16];
  logic [31:0] m_tmp1;
  logic [3:0]  m_cpsr;
  logic [31:0] last_pc_wd;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_r[13] = 32'h0000_1FFC;
    m_r[15] = 32'h0000_0002;
    m_tmp1  = '0;
    m_cpsr  = '0;
  endtask

  function automatic logic [31:0] ofs(input int sel);
    return (sel == 15) ? 32'd2 : 32'd0;
  endfunction

  // port 0..3 = A..D
  function automatic logic [31:0] m_read(input int port, input logic [4:0] sel);
    logic [31:0] v;
    v = '0;
    if (sel < 16)                   v = m_r[sel[3:0]];
    else if (sel == 30 && port < 2) v = m_tmp1;
    else if (sel == 31 && port == 0) v = immediate1_in;
    else if (sel == 31 && port == 1) v = immediate2_in;
`ifdef REGFILE_BYPASS_EN
    if (sel < 16 || (sel == 30 && port < 2)) begin
      if (write2_en && write2_sel == sel) v = write2_in + ofs(int'(sel));
      if (write1_en && write1_sel == sel) v = write1_in + ofs(int'(sel));
    end
`endif
    return v;
  endfunction

  // Advance one clock; the model applies the same cycle's writes in rising priority order.
  task automatic step(input bit pw, input int psel, input logic [31:0] pd,
                      input bit su, input logic [31:0] sv);
    logic [31:0] nr [16];
    logic [31:0] nt;
    logic [3:0]  nc;
    for (int i = 0; i < 16; i++) nr[i] = m_r[i];
    nt = m_tmp1;
    nc = next_cpsr_in;
    if (next_pc_en) nr[15] = next_pc_in;
    if (next_sp_en) nr[13] = next_sp_in;
    if (write2_en && write2_sel < 16)  nr[write2_sel[3:0]] = write2_in + ofs(int'(write2_sel));
    if (write2_en && write2_sel == 30) nt = write2_in;
    if (write1_en && write1_sel < 16)  nr[write1_sel[3:0]] = write1_in + ofs(int'(write1_sel));
    if (write1_en && write1_sel == 30) nt = write1_in;
    if (pw) nr[psel] = pd + ofs(psel);
    if (su) nr[13] = sv;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) m_r[i] = nr[i];
    m_tmp1 = nt;
    m_cpsr = nc;
  endtask

  task automatic step_plain();
    step(1'b0, 0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic idle_writes();
    write1_en = 1'b0; write2_en = 1'b0; next_pc_en = 1'b0; next_sp_en = 1'b0;
  endtask

  task automatic chk_reads(input string tag);
    readA_sel = 5'($urandom_range(0, 31)); readB_sel = 5'($urandom_range(0, 31));
    readC_sel = 5'($urandom_range(0, 31)); readD_sel = 5'($urandom_range(0, 31));
    immediate1_in = $urandom; immediate2_in = $urandom;
    #1;
    chk({tag, "_A"}, regA_out, m_read(0, readA_sel));
    chk({tag, "_B"}, regB_out, m_read(1, readB_sel));
    chk({tag, "_C"}, regC_out, m_read(2, readC_sel));
    chk({tag, "_D"}, regD_out, m_read(3, readD_sel));
    chk({tag, "_sp"}, sp_out, m_r[13]);
    chk({tag, "_pc"}, pc_out, m_r[15]);
    chk({tag, "_cpsr"}, {28'd0, cpsr_out}, {28'd0, m_cpsr});
  endtask

  // One full list transfer; the expected beat order is simply the ascending set bits of the mask.
  task automatic run_list(input string tag, input logic [15:0] mask, input bit pop,
                          input int stall0, input int max_stall, input bit collide);
    int q[$];
    int st;
    logic [31:0] sp0, base, n4, wd, newsp;
    for (int i = 0; i < 16; i++) if (mask[i] && i != 13) q.push_back(i);
    n4   = 32'(4 * q.size());
    sp0  = m_r[13];
    base = pop ? sp0 : sp0 - n4;
    lif.list_start = 1'b1; lif.list_mask = mask; lif.list_pop = pop; lif.list_ready = 1'b0;
    #1;
    chk({tag, "_idle_busy"}, {31'd0, lif.list_busy}, 32'd0);
    step_plain();
    lif.list_start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      st = (k == 0) ? stall0 : $urandom_range(0, max_stall);
      for (int s = 0; s <= st; s++) begin
        wd = $urandom;
        lif.list_ready = (s == st);
        lif.list_wdata = wd;
        if (k == 0 && s == 0) begin
          lif.list_start = 1'b1; lif.list_mask = 16'hFFFF; lif.list_pop = ~pop;
        end
        if (collide && s == st) begin
          write1_en = 1'b1; write1_sel = 5'(q[k]); write1_in = ~wd;
        end
        #1;
        chk({tag, "_valid"}, {31'd0, lif.list_valid}, 32'd1);
        chk({tag, "_busy"},  {31'd0, lif.list_busy}, 32'd1);
        chk({tag, "_sel"},   {28'd0, lif.list_sel}, 32'(q[k]));
        chk({tag, "_addr"},  lif.list_addr, base + 32'(4 * k));
        if (!pop) chk({tag, "_rdata"}, lif.list_rdata, m_r[q[k]]);
        if (pop && s == st && q[k] == 15) last_pc_wd = wd;
        step(pop && (s == st), q[k], wd, 1'b0, 32'd0);
        lif.list_start = 1'b0;
        write1_en = 1'b0;
      end
    end
    lif.list_ready = 1'b0;
    newsp = pop ? sp0 + n4 : sp0 - n4;
    lif.list_start = 1'b1; lif.list_mask = 16'h0001; lif.list_pop = 1'b0;
    if (collide) begin
      next_sp_en = 1'b1; next_sp_in = $urandom;
      write1_en = 1'b1; write1_sel = 5'd13; write1_in = $urandom;
    end
    #1;
    chk({tag, "_done"},      {31'd0, lif.list_done}, 32'd1);
    chk({tag, "_done_busy"}, {31'd0, lif.list_busy}, 32'd1);
    chk({tag, "_done_vld"},  {31'd0, lif.list_valid}, 32'd0);
    step(1'b0, 0, 32'd0, 1'b1, newsp);
    lif.list_start = 1'b0;
    idle_writes();
    #1;
    chk({tag, "_after_busy"}, {31'd0, lif.list_busy}, 32'd0);
    chk({tag, "_after_done"}, {31'd0, lif.list_done}, 32'd0);
    chk({tag, "_after_sel"},  {28'd0, lif.list_sel}, 32'd0);
    chk({tag, "_after_addr"}, lif.list_addr, 32'd0);
    chk({tag, "_sp"}, sp_out, m_r[13]);
  endtask

  initial begin
    reset = 1'b1;
    idle_writes();
    write1_sel = '0; write2_sel = '0; write1_in = '0; write2_in = '0;
    next_pc_in = '0; next_sp_in = '0; next_cpsr_in = '0;
    readA_sel = '0; readB_sel = '0; readC_sel = '0; readD_sel = '0;
    immediate1_in = '0; immediate2_in = '0;
    lif.list_start = 1'b0; lif.list_mask = '0; lif.list_pop = 1'b0;
    lif.list_ready = 1'b0; lif.list_wdata = '0;
    last_pc_wd = '0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;

    // Reset state, observed while reset is still held
    for (int s = 0; s < 16; s++) begin
      readA_sel = 5'(s); readC_sel = 5'(s);
      #1;
      chk("rst_A", regA_out, m_read(0, readA_sel));
      chk("rst_C", regC_out, m_read(2, readC_sel));
    end
    readB_sel = 5'd30; #1;
    chk("rst_tmp1", regB_out, 32'd0);
    chk("rst_sp", sp_out, 32'h0000_1FFC);
    chk("rst_pc", pc_out, 32'h0000_0002);
    chk("rst_cpsr", {28'd0, cpsr_out}, 32'd0);
    chk("rst_busy", {31'd0, lif.list_busy}, 32'd0);
    chk("rst_valid", {31'd0, lif.list_valid}, 32'd0);
    chk("rst_done", {31'd0, lif.list_done}, 32'd0);
    chk("rst_sel", {28'd0, lif.list_sel}, 32'd0);
    chk("rst_addr", lif.list_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // write1 beats write2 on the same register
    write1_en = 1'b1; write1_sel = 5'd3; write1_in = 32'hA;
    write2_en = 1'b1; write2_sel = 5'd3; write2_in = 32'hB;
    step_plain(); idle_writes();
    readA_sel = 5'd3; #1;
    chk("w1_over_w2_r3", regA_out, 32'hA);

    write1_en = 1'b1; write1_sel = 5'd15; write1_in = 32'h100;
    step_plain(); idle_writes(); #1;
    chk("pc_w1_ofs", pc_out, 32'h102);

    write2_en = 1'b1; write2_sel = 5'd15; write2_in = 32'h200;
    next_pc_en = 1'b1; next_pc_in = 32'h300;
    step_plain(); idle_writes(); #1;
    chk("pc_w2_over_next", pc_out, 32'h202);

    next_pc_en = 1'b1; next_pc_in = 32'h400;
    step_plain(); idle_writes(); #1;
    chk("pc_next_only", pc_out, 32'h400);

    next_sp_en = 1'b1; next_sp_in = 32'h1000;
    write2_en = 1'b1; write2_sel = 5'd13; write2_in = 32'h2000;
    step_plain(); idle_writes(); #1;
    chk("sp_w2_over_next", sp_out, 32'h2000);

    write1_en = 1'b1; write1_sel = 5'd30; write1_in = 32'hDEAD;
    next_cpsr_in = 4'h9;
    step_plain(); idle_writes();
    readB_sel = 5'd30; readC_sel = 5'd30; #1;
    chk("tmp1_B", regB_out, 32'hDEAD);
    chk("tmp1_C_zero", regC_out, 32'd0);
    chk("cpsr_load", {28'd0, cpsr_out}, 32'h9);

    write1_en = 1'b1; write1_sel = 5'd5; write1_in = 32'h55;
    readA_sel = 5'd5; #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_r5", regA_out, 32'h55);
`else
    chk("nobypass_r5", regA_out, 32'h0);
`endif
    step_plain(); idle_writes(); #1;
    chk("r5_written", regA_out, 32'h55);

    for (int c = 0; c < 40; c++) begin
      write1_en = 1'($urandom_range(0, 1)); write1_sel = 5'($urandom_range(0, 31)); write1_in = $urandom;
      write2_en = 1'($urandom_range(0, 1)); write2_sel = 5'($urandom_range(0, 31)); write2_in = $urandom;
      next_pc_en = 1'($urandom_range(0, 1)); next_pc_in = $urandom;
      next_sp_en = 1'($urandom_range(0, 1)); next_sp_in = $urandom;
      next_cpsr_in = 4'($urandom_range(0, 15));
      chk_reads("rnd");
      step_plain();
    end
    idle_writes();

    // Directed list transfers from a fresh reset
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0; m_reset();
    write1_en = 1'b1; write1_sel = 5'd0; write1_in = 32'h11;
    write2_en = 1'b1; write2_sel = 5'd4; write2_in = 32'h44;
    step_plain();
    write2_en = 1'b0; write1_sel = 5'd14; write1_in = 32'hEE;
    step_plain(); idle_writes();
    run_list("push4011", 16'h4011, 1'b0, 0, 0, 1'b0);
    chk("push_sp_final", sp_out, 32'h1FF0);

    run_list("pop8002", 16'h8002, 1'b1, 2, 0, 1'b1);
    chk("pop_sp_final", sp_out, 32'h1FF8);
    chk("pop_pc_final", pc_out, last_pc_wd + 32'd2);

    run_list("sp_only", 16'h2000, 1'b0, 0, 0, 1'b0);
    chk("sp_only_final", sp_out, 32'h1FF8);

    // Reset during the third beat of a 3-register PUSH
    lif.list_start = 1'b1; lif.list_mask = 16'h0007; lif.list_pop = 1'b0;
    step_plain();
    lif.list_start = 1'b0; lif.list_ready = 1'b1;
    step_plain(); step_plain();
    #1;
    chk("mr_sel_beat2", {28'd0, lif.list_sel}, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; lif.list_ready = 1'b0; m_reset();
    #1;
    chk("mr_busy", {31'd0, lif.list_busy}, 32'd0);
    chk("mr_valid", {31'd0, lif.list_valid}, 32'd0);
    chk("mr_sp", sp_out, 32'h1FFC);
    chk("mr_addr", lif.list_addr, 32'd0);

    for (int it = 0; it < 6; it++) begin
      next_sp_en = 1'b1; next_sp_in = 32'h1000 + 32'($urandom_range(0, 255) << 2);
      step_plain(); idle_writes();
      for (int c = 0; c < 3; c++) begin
        write1_en = 1'b1; write1_sel = 5'($urandom_range(0, 15)); write1_in = $urandom;
        if (write1_sel == 5'd13) write1_sel = 5'd12;
        step_plain();
      end
      idle_writes();
      run_list("rndlist", 16'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 2, 1'($urandom_range(0, 1)));
      chk_reads("post_list");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
